pipe_stage_latch: RTL and testbench

Parametrised pipeline-stage register that generalises the fixed inter-stage latches (IF/ID … MEM/WB) into one reusable block. It carries N_DATA payload lanes of DATA_W bits plus CTRL_W control bits with a valid/ready handshake. An optional 2-entry skid buffer, a synchronous flush, and a debug single-step gate are provided. It sits between any two pipeline stages; bubbles always present all-zero control bits downstream.

---
 rtl/pipe_stage_latch.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_latch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_latch.sv
// Reusable pipeline-stage register: N_DATA payload lanes plus a control bundle behind a
// valid/ready handshake, with an optional 2-entry skid buffer, synchronous flush and debug single-step.
module pipe_stage_latch #(
  parameter int DATA_W = 32,
  parameter int N_DATA = 4,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [N_DATA*DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0]        i_ctrl,
  input  logic                     i_flush,
  input  logic                     i_debug_en,
  input  logic                     i_step,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [N_DATA*DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0]        o_ctrl,
  output logic [1:0]               o_occupancy
);

  localparam int PW = N_DATA * DATA_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic              en_s;
  logic              ready_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              ready_q;
  logic              ready_d;
  logic [PW-1:0]     main_data_q;
  logic [PW-1:0]     main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [PW-1:0]     skid_data_q;
  logic [PW-1:0]     skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_d;

  assign en_s       = ~i_debug_en | i_step;
  assign o_valid    = (state_q != ST_EMPTY);
  assign out_fire_s = o_valid & i_ready & en_s;
  assign in_fire_s  = i_valid & ready_s;

  // Skid build takes ready from a flag so i_ready never reaches o_ready combinationally.
  generate
    if (SKID != 0) begin : g_skid
      assign ready_s = ready_q & en_s;
    end else begin : g_single
      assign ready_s = (~o_valid | i_ready) & en_s;
    end
  endgenerate

  assign o_ready     = ready_s;
  assign o_data      = main_data_q;
  assign o_ctrl      = main_ctrl_q;
  assign o_occupancy = state_q;

  // Next-state: control is zeroed whenever the stage goes empty so o_ctrl stays a plain register.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (i_flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = {CTRL_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d     = ST_ONE;
            main_data_d = i_data;
            main_ctrl_d = i_ctrl;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_data_d = i_data;
            main_ctrl_d = i_ctrl;
          end else if (in_fire_s) begin
            state_d     = ST_FULL;
            skid_data_d = i_data;
            skid_ctrl_d = i_ctrl;
          end else if (out_fire_s) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = {CTRL_W{1'b0}};
          skid_ctrl_d = {CTRL_W{1'b0}};
        end
      endcase
    end
    ready_d = (state_d != ST_FULL);
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      ready_q     <= 1'b1;
      main_data_q <= {PW{1'b0}};
      main_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {PW{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch: skid build (dut) and single-register build (dut0)
// side by side, each scenario in its own task with inline comparisons.
module tb_pipe_stage_latch;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid, flush, dbg, step, rdy;
  logic [127:0] data;
  logic [7:0]   ctrl;
  logic         o_ready, o_valid;
  logic [127:0] o_data;
  logic [7:0]   o_ctrl;
  logic [1:0]   occ;

  logic         z_valid, z_flush, z_dbg, z_step, z_rdy;
  logic [127:0] z_data;
  logic [7:0]   z_ctrl;
  logic         z_o_ready, z_o_valid;
  logic [127:0] z_o_data;
  logic [7:0]   z_o_ctrl;
  logic [1:0]   z_occ;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_latch #(.DATA_W(32), .N_DATA(4), .CTRL_W(8), .SKID(1)) dut (
    .clk(clk), .rst(rst), .i_valid(valid), .o_ready(o_ready), .i_data(data), .i_ctrl(ctrl),
    .i_flush(flush), .i_debug_en(dbg), .i_step(step), .o_valid(o_valid), .i_ready(rdy),
    .o_data(o_data), .o_ctrl(o_ctrl), .o_occupancy(occ)
  );

  pipe_stage_latch #(.DATA_W(32), .N_DATA(4), .CTRL_W(8), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .i_valid(z_valid), .o_ready(z_o_ready), .i_data(z_data), .i_ctrl(z_ctrl),
    .i_flush(z_flush), .i_debug_en(z_dbg), .i_step(z_step), .o_valid(z_o_valid), .i_ready(z_rdy),
    .o_data(z_o_data), .o_ctrl(z_o_ctrl), .o_occupancy(z_occ)
  );

  // Distinct value per lane so lane swaps or truncation are visible; lane0 = v.
  function automatic logic [127:0] mk(input logic [31:0] v);
    return {v ^ 32'hA5A5A5A5, v ^ 32'h5A5A5A5A, ~v, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", o_valid); else pass_cnt++;
    total_cnt++; if (o_ctrl !== 8'h00) $display("FAIL rst_ctrl got=%h exp=00", o_ctrl); else pass_cnt++;
    total_cnt++; if (occ !== 2'd0) $display("FAIL rst_occ got=%0d exp=0", occ); else pass_cnt++;
    total_cnt++; if (o_data !== 128'd0) $display("FAIL rst_data got=%h exp=0", o_data); else pass_cnt++;
    total_cnt++; if (o_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", o_ready); else pass_cnt++;
    total_cnt++; if (z_o_valid !== 1'b0 || z_occ !== 2'd0 || z_o_ctrl !== 8'h00)
      $display("FAIL rst_skid0 got valid=%b occ=%0d ctrl=%h exp 0/0/00", z_o_valid, z_occ, z_o_ctrl); else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_pass_through();
    rdy = 1'b1; valid = 1'b1; data = mk(32'hDEADBEEF); ctrl = 8'h05;
    tick();
    total_cnt++; if (o_valid !== 1'b1) $display("FAIL pt_valid got=%b exp=1", o_valid); else pass_cnt++;
    total_cnt++; if (o_data !== mk(32'hDEADBEEF)) $display("FAIL pt_data got=%h exp=%h", o_data, mk(32'hDEADBEEF)); else pass_cnt++;
    total_cnt++; if (o_ctrl !== 8'h05) $display("FAIL pt_ctrl got=%h exp=05", o_ctrl); else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      data = mk(32'h1000_0000 + i); ctrl = 8'h10 + 8'(i);
      tick();
      total_cnt++; if (o_data !== mk(32'h1000_0000 + i) || o_ctrl !== 8'h10 + 8'(i) || occ !== 2'd1)
        $display("FAIL b2b_%0d got data=%h ctrl=%h occ=%0d exp ctrl=%h occ=1", i, o_data, o_ctrl, occ, 8'h10 + 8'(i)); else pass_cnt++;
    end
    valid = 1'b0;
    tick();
    total_cnt++; if (o_valid !== 1'b0 || o_ctrl !== 8'h00 || occ !== 2'd0)
      $display("FAIL pt_drain got valid=%b ctrl=%h occ=%0d exp 0/00/0", o_valid, o_ctrl, occ); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    rdy = 1'b0; valid = 1'b1; data = mk(32'h11); ctrl = 8'h0A;
    tick();
    total_cnt++; if (occ !== 2'd1 || o_ready !== 1'b1) $display("FAIL bp_one got occ=%0d ready=%b exp 1/1", occ, o_ready); else pass_cnt++;
    data = mk(32'h22); ctrl = 8'h0B;
    tick();
    total_cnt++; if (occ !== 2'd2 || o_ready !== 1'b0) $display("FAIL bp_full got occ=%0d ready=%b exp 2/0", occ, o_ready); else pass_cnt++;
    total_cnt++; if (o_data !== mk(32'h11) || o_ctrl !== 8'h0A) $display("FAIL bp_headA got data=%h ctrl=%h exp ctrl=0A", o_data, o_ctrl); else pass_cnt++;
    valid = 1'b0; rdy = 1'b1;
    tick();
    total_cnt++; if (o_data !== mk(32'h22) || o_ctrl !== 8'h0B || occ !== 2'd1)
      $display("FAIL bp_headB got data=%h ctrl=%h occ=%0d exp ctrl=0B occ=1", o_data, o_ctrl, occ); else pass_cnt++;
    total_cnt++; if (o_ready !== 1'b1) $display("FAIL bp_ready_back got=%b exp=1", o_ready); else pass_cnt++;
    tick();
    total_cnt++; if (o_valid !== 1'b0 || occ !== 2'd0) $display("FAIL bp_empty got valid=%b occ=%0d exp 0/0", o_valid, occ); else pass_cnt++;
  endtask

  task automatic test_flush();
    rdy = 1'b0; valid = 1'b1; data = mk(32'h11); ctrl = 8'h0A;
    tick();
    data = mk(32'h22); ctrl = 8'h0B;
    tick();
    data = mk(32'h33); ctrl = 8'h0C; flush = 1'b1;
    total_cnt++; if (o_ready !== 1'b0) $display("FAIL fl_full_ready got=%b exp=0", o_ready); else pass_cnt++;
    tick();
    total_cnt++; if (o_valid !== 1'b0 || o_ctrl !== 8'h00 || occ !== 2'd0)
      $display("FAIL fl_kill got valid=%b ctrl=%h occ=%0d exp 0/00/0", o_valid, o_ctrl, occ); else pass_cnt++;
    flush = 1'b0; valid = 1'b0; rdy = 1'b1;
    tick(); tick(); tick();
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL fl_no_C got valid=%b exp=0", o_valid); else pass_cnt++;
    valid = 1'b1; data = mk(32'h44); ctrl = 8'h0D; flush = 1'b1;
    total_cnt++; if (o_ready !== 1'b1) $display("FAIL fl_ready_ungated got=%b exp=1", o_ready); else pass_cnt++;
    tick();
    total_cnt++; if (o_valid !== 1'b0 || occ !== 2'd0) $display("FAIL fl_discard got valid=%b occ=%0d exp 0/0", o_valid, occ); else pass_cnt++;
    flush = 1'b0; valid = 1'b0;
  endtask

  task automatic test_debug_step();
    int bad;
    rdy = 1'b0; valid = 1'b1; data = mk(32'hA1); ctrl = 8'h21;
    tick();
    data = mk(32'hB2); ctrl = 8'h22; dbg = 1'b1; rdy = 1'b1;
    #1;
    total_cnt++; if (o_ready !== 1'b0) $display("FAIL dbg_ready_gated got=%b exp=0", o_ready); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_valid !== 1'b1 || o_data !== mk(32'hA1) || o_ctrl !== 8'h21 || occ !== 2'd1) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL dbg_frozen got %0d bad cycles exp 0", bad); else pass_cnt++;
    step = 1'b1;
    #1;
    total_cnt++; if (o_ready !== 1'b1) $display("FAIL dbg_step_ready got=%b exp=1", o_ready); else pass_cnt++;
    tick();
    step = 1'b0;
    total_cnt++; if (o_data !== mk(32'hB2) || o_ctrl !== 8'h22 || occ !== 2'd1)
      $display("FAIL dbg_step got data=%h ctrl=%h occ=%0d exp ctrl=22 occ=1", o_data, o_ctrl, occ); else pass_cnt++;
    data = mk(32'hC3); ctrl = 8'h23;
    tick(); tick(); tick();
    total_cnt++; if (o_data !== mk(32'hB2) || o_ctrl !== 8'h22 || occ !== 2'd1)
      $display("FAIL dbg_refreeze got data=%h ctrl=%h occ=%0d exp ctrl=22 occ=1", o_data, o_ctrl, occ); else pass_cnt++;
    dbg = 1'b0; valid = 1'b0;
    tick();
    total_cnt++; if (o_valid !== 1'b0 || occ !== 2'd0) $display("FAIL dbg_release got valid=%b occ=%0d exp 0/0", o_valid, occ); else pass_cnt++;
  endtask

  task automatic test_skid0();
    z_rdy = 1'b0; z_valid = 1'b1; z_data = mk(32'h55); z_ctrl = 8'h31;
    #1;
    total_cnt++; if (z_o_ready !== 1'b1) $display("FAIL s0_ready_empty got=%b exp=1", z_o_ready); else pass_cnt++;
    tick();
    total_cnt++; if (z_o_valid !== 1'b1 || z_o_data !== mk(32'h55) || z_occ !== 2'd1)
      $display("FAIL s0_load got valid=%b data=%h occ=%0d exp 1/occ=1", z_o_valid, z_o_data, z_occ); else pass_cnt++;
    total_cnt++; if (z_o_ready !== 1'b0) $display("FAIL s0_ready_bp got=%b exp=0", z_o_ready); else pass_cnt++;
    z_rdy = 1'b1; z_data = mk(32'h66); z_ctrl = 8'h32;
    #1;
    total_cnt++; if (z_o_ready !== 1'b1) $display("FAIL s0_ready_comb got=%b exp=1", z_o_ready); else pass_cnt++;
    tick();
    total_cnt++; if (z_o_data !== mk(32'h66) || z_o_ctrl !== 8'h32 || z_occ !== 2'd1)
      $display("FAIL s0_both_fire got data=%h ctrl=%h occ=%0d exp ctrl=32 occ=1", z_o_data, z_o_ctrl, z_occ); else pass_cnt++;
    z_dbg = 1'b1;
    #1;
    total_cnt++; if (z_o_ready !== 1'b0) $display("FAIL s0_dbg_gate got=%b exp=0", z_o_ready); else pass_cnt++;
    z_dbg = 1'b0; z_valid = 1'b0;
    tick();
    total_cnt++; if (z_o_valid !== 1'b0 || z_o_ctrl !== 8'h00 || z_occ !== 2'd0)
      $display("FAIL s0_drain got valid=%b ctrl=%h occ=%0d exp 0/00/0", z_o_valid, z_o_ctrl, z_occ); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0; valid = 1'b1; data = mk(32'h77); ctrl = 8'h41;
    tick();
    data = mk(32'h88); ctrl = 8'h42;
    tick();
    total_cnt++; if (occ !== 2'd2) $display("FAIL rm_fill got occ=%0d exp=2", occ); else pass_cnt++;
    valid = 1'b0; rst = 1'b0; flush = 1'b0; dbg = 1'b1; step = 1'b1;
    tick();
    total_cnt++; if (o_valid !== 1'b0 || o_ctrl !== 8'h00 || o_data !== 128'd0 || occ !== 2'd0)
      $display("FAIL rm_zero got valid=%b ctrl=%h data=%h occ=%0d exp all 0", o_valid, o_ctrl, o_data, occ); else pass_cnt++;
    rst = 1'b1; dbg = 1'b0; step = 1'b0;
    #1;
    total_cnt++; if (o_ready !== 1'b1) $display("FAIL rm_ready got=%b exp=1", o_ready); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; flush = 1'b0; dbg = 1'b0; step = 1'b0; rdy = 1'b0;
    data = 128'd0; ctrl = 8'h00;
    z_valid = 1'b0; z_flush = 1'b0; z_dbg = 1'b0; z_step = 1'b0; z_rdy = 1'b0;
    z_data = 128'd0; z_ctrl = 8'h00;
    test_reset();
    test_pass_through();
    test_backpressure();
    test_flush();
    test_debug_step();
    test_skid0();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
